lfsr_rng_stream: RTL and testbench

//   Parametrised Fibonacci LFSR random-number source with a valid/ready output stream.

---
 rtl/lfsr_rng_stream.sv | 87 ++++++++
 tb/tb_lfsr_rng_stream.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/lfsr_rng_stream.sv
// Fibonacci LFSR random source with valid/ready output stream.
// Ports: clk, rst (sync, active-high), seed/seed_load reload,
// enable gates stepping, limit bounds accepted words (0 = full range),
// rand_out/out_valid/out_ready form the output handshake.
module lfsr_rng_stream #(
  parameter int               WIDTH        = 12,
  parameter logic [WIDTH-1:0] TAPS         = 12'h053,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 12'h001
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] seed,
  input  logic             seed_load,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] rand_out,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {
    GEN,
    HOLD
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] lfsr;
  logic [7:0]       step_cnt;

  logic             fb;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] cand;
  logic             last_step;
  logic             accept;

  always_comb begin
    fb        = ^(lfsr & TAPS);
    lfsr_next = {fb, lfsr[WIDTH-1:1]};
    // lfsr is never zero, so cand spans 0 .. 2^WIDTH-2
    cand      = lfsr_next - WIDTH'(1);
    last_step = (step_cnt == 8'(STEPS - 1));
    accept    = (limit == '0) || (cand < limit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED_DEFAULT;
      rand_out  <= '0;
      out_valid <= 1'b0;
      step_cnt  <= '0;
      state     <= GEN;
    end else if (seed_load) begin
      // all-zero seed would lock the LFSR
      lfsr      <= (seed == '0) ? '1 : seed;
      out_valid <= 1'b0;
      step_cnt  <= '0;
      state     <= GEN;
    end else begin
      unique case (state)
        GEN: begin
          if (enable) begin
            lfsr <= lfsr_next;
            if (last_step) begin
              step_cnt <= '0;
              if (accept) begin
                rand_out  <= cand;
                out_valid <= 1'b1;
                state     <= HOLD;
              end
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= GEN;
          end
        end
        default: state <= GEN;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_stream.sv
// Scoreboard bench for lfsr_rng_stream.
// Main instance STEPS=1, second instance STEPS=4.
module tb_lfsr_rng_stream;

  logic        clk = 1'b0;
  logic        rst, seed_load, enable, out_ready, out_valid;
  logic [11:0] seed, limit, rand_out;

  logic        rst4, seed_load4, enable4, out_ready4, out_valid4;
  logic [11:0] seed4, limit4, rand_out4;

  int pass_cnt = 0;
  int total    = 0;
  int pushed   = 0;
  int popped   = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  lfsr_rng_stream dut (
    .clk(clk), .rst(rst), .seed(seed), .seed_load(seed_load),
    .enable(enable), .limit(limit), .rand_out(rand_out),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  lfsr_rng_stream #(.STEPS(4)) dut4 (
    .clk(clk), .rst(rst4), .seed(seed4), .seed_load(seed_load4),
    .enable(enable4), .limit(limit4), .rand_out(rand_out4),
    .out_valid(out_valid4), .out_ready(out_ready4)
  );

  task automatic chk(input string name, input logic [11:0] act,
                     input logic [11:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [11:0] v);
    exp_q.push_back(v);
    pushed++;
  endtask

  task automatic take();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  // monitor: a handshake completes at the coming edge
  always @(negedge clk) begin
    if (!rst && !seed_load && out_valid && out_ready) begin
      popped++;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", rand_out, 12'hxxx);
      end else begin
        chk("word", rand_out, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1; seed_load = 0; enable = 1; out_ready = 0;
    seed = 0; limit = 0;
    rst4 = 1; seed_load4 = 0; enable4 = 0; out_ready4 = 0;
    seed4 = 0; limit4 = 0;

    // 1: reset, first word
    step(); step();
    chk("rst_valid", 12'(out_valid), 12'h0);
    chk("rst_rand", rand_out, 12'h000);
    rst = 0;
    push(12'h7FF);
    step();
    chk("lat1_valid", 12'(out_valid), 12'h1);
    step(); step(); step();
    chk("hold_valid", 12'(out_valid), 12'h1);
    chk("hold_rand", rand_out, 12'h7FF);

    // 2: handshake then next word
    take();
    chk("after_take", 12'(out_valid), 12'h0);
    push(12'h3FF);
    step();
    chk("w2_valid", 12'(out_valid), 12'h1);
    take();

    // 3: zero seed -> all ones
    seed = 12'h000; seed_load = 1;
    step();
    seed_load = 0;
    push(12'h7FE);
    step();
    chk("zseed_valid", 12'(out_valid), 12'h1);
    take();

    // 4: limit forces one reject
    seed = 12'h001; seed_load = 1; limit = 12'h400;
    step();
    seed_load = 0;
    push(12'h3FF);
    step();
    chk("reject_valid", 12'(out_valid), 12'h0);
    step();
    chk("accept_valid", 12'(out_valid), 12'h1);
    limit = 12'h001;
    step();
    chk("limit_hold", rand_out, 12'h3FF);
    take();
    limit = 0;

    // 6: seed_load wins over handshake
    seed = 12'h001; seed_load = 1;
    step();
    seed_load = 0;
    step();
    chk("pre_drop", rand_out, 12'h7FF);
    seed = 12'h800; seed_load = 1; out_ready = 1;
    step();
    chk("drop_valid", 12'(out_valid), 12'h0);
    seed_load = 0; out_ready = 0;
    push(12'h3FF);
    step();
    chk("reseed_valid", 12'(out_valid), 12'h1);
    take();

    // rst while holding
    seed = 12'h001; seed_load = 1;
    step();
    seed_load = 0;
    step();
    rst = 1;
    step();
    chk("rst_hold_valid", 12'(out_valid), 12'h0);
    chk("rst_hold_rand", rand_out, 12'h000);
    rst = 0;
    push(12'h7FF);
    step();
    take();

    // 5: STEPS=4 latency, then enable gap
    rst4 = 0; enable4 = 1;
    step(); step(); step();
    chk("s4_early", 12'(out_valid4), 12'h0);
    step();
    chk("s4_valid", 12'(out_valid4), 12'h1);
    chk("s4_rand", rand_out4, 12'h0FF);
    seed4 = 12'h001; seed_load4 = 1;
    step();
    seed_load4 = 0;
    step(); step();
    enable4 = 0;
    step(); step(); step();
    chk("s4_frozen", 12'(out_valid4), 12'h0);
    enable4 = 1;
    step();
    chk("s4_third", 12'(out_valid4), 12'h0);
    step();
    chk("s4_gap_valid", 12'(out_valid4), 12'h1);
    chk("s4_gap_rand", rand_out4, 12'h0FF);

    step();
    chk("sb_empty", 12'(exp_q.size()), 12'h0);
    chk("sb_count", 12'(popped), 12'(pushed));

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
